iob_axil_master_bridge: RTL
===========================

// Module: iob_axil_master_bridge
// PURPOSE
//   Converts single-word IOb native requests (from the CPU data-bus split) into AXI4-Lite master transactions, one at a time.
//   Sits between the bus split's external-memory/peripheral slave port and an AXI4-Lite interconnect or slave.
// PARAMETERS
//   ADDR_W  32  IOb and AXI byte-address width (passed through unchanged)
//   DATA_W  32  IOb and AXI data width; wstrb width is DATA_W/8
// PORTS
//   clk      in   1         system clock
//   rst      in   1         synchronous reset, active-low (asserted when 0)
//   valid    in   1         IOb request valid; held with addr/wdata/wstrb until ready
//   addr     in   ADDR_W    IOb byte address
//   wdata    in   DATA_W    IOb write data
//   wstrb    in   DATA_W/8  IOb byte strobes; nonzero = write, zero = read
//   rdata    out  DATA_W    read data, valid while ready=1, held until next read completes
//   ready    out  1         one-cycle completion pulse
//   error    out  1         high with ready when the AXI response was SLVERR/DECERR
//   awaddr   out  ADDR_W    AXI write address
//   awvalid  out  1         AXI write-address valid
//   awready  in   1         AXI write-address ready
//   wdata_o  out  DATA_W    AXI write data
//   wstrb_o  out  DATA_W/8  AXI write strobes
//   wvalid   out  1         AXI write-data valid
//   wready   in   1         AXI write-data ready
//   bresp    in   2         AXI write response
//   bvalid   in   1         AXI write-response valid
//   bready   out  1         AXI write-response ready
//   araddr   out  ADDR_W    AXI read address
//   arvalid  out  1         AXI read-address valid
//   arready  in   1         AXI read-address ready
//   rdata_i  in   DATA_W    AXI read data
//   rresp    in   2         AXI read response
//   rvalid   in   1         AXI read-data valid
//   rready   out  1         AXI read-data ready
// BEHAVIOUR
// - All outputs are registered. On reset (rst==0 at a clk edge): state=IDLE; awvalid, wvalid, bready, arvalid, rready, ready, error=0; rdata, awaddr, araddr, wdata_o, wstrb_o=0.
// - Reset mid-transaction abandons it, with no completion pulse. The AXI slave is reset by the same rst.
// - FSM: IDLE -> WR (|wstrb) or RD (wstrb==0) -> WRESP / RDATA -> DONE -> IDLE.
// - IDLE: when valid=1, latch addr/wdata/wstrb. Assert awvalid+wvalid, or arvalid, on the next cycle.
// - WR: awvalid and wvalid are tracked independently. Each drops the cycle after its own valid&ready handshake.
//   Leave WR once both handshakes are done, including when both occur in the same cycle. Then bready=1 in WRESP.
// - WRESP: on bvalid&bready: bready=0, error<=bresp[1], go to DONE.
// - RD: arvalid held until arready, then arvalid=0 and rready=1 in RDATA.
// - RDATA: on rvalid&rready: rdata<=rdata_i, error<=rresp[1], rready=0, go to DONE.
// - DONE: ready=1 for exactly one cycle and valid is ignored. IDLE samples valid again on the next cycle.
// - Minimum latency with zero-wait slaves: ready is asserted 3 cycles after the IDLE cycle that sampled valid.
// - AXI valids never drop before their handshake. No new AXI request is issued while one is outstanding; exactly one transaction is in flight at a time.
// - Responses arriving in the wrong state are ignored: bready/rready stay 0 outside WRESP/RDATA.
// - error is 0 whenever ready is 0. rdata is unchanged by writes.
// TESTING
// 1. Write addr=0x100, wdata=0xDEADBEEF, wstrb=0xF, slave always ready, bresp=0 -> awaddr=0x100, wstrb_o=0xF; ready 3 cycles after sample; error=0.
// 2. Write with awready delayed 4 cycles, wready immediate -> wvalid high 1 cycle, awvalid high 5 cycles; bready only after both handshakes; a single ready pulse.
// 3. Read addr=0x204 (wstrb=0), arready delayed 2 cycles, rdata_i=0x12345678, rresp=0 -> rdata=0x12345678 with ready; value held after ready drops.
// 4. bresp=2'b10, then a read with rresp=2'b11 -> error=1 coincident with each ready pulse, 0 otherwise.
// 5. rst=0 while in RDATA -> next cycle all AXI valids/readies and ready=0. After release, write 0x55 to 0x8 completes normally.
// 6. valid held high across DONE with a new read request -> exactly one AXI transaction per request; no duplicate arvalid.

Source files
------------

// File: rtl/iob_axil_master_bridge.sv
// IOb native single-word requests to AXI4-Lite master transactions, one in flight at a time.
// Every output is driven from the single registered state machine below.
module iob_axil_master_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic                  error,
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W/8-1:0]   wstrb_o,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WRESP = 3'd2,
        RD    = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state_reg;

    // A channel counts as finished once its valid has dropped or is handshaking now.
    logic aw_ok;
    logic w_ok;

    assign aw_ok = !awvalid || awready;
    assign w_ok  = !wvalid  || wready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            ready     <= 1'b0;
            error     <= 1'b0;
            rdata     <= '0;
            awaddr    <= '0;
            araddr    <= '0;
            wdata_o   <= '0;
            wstrb_o   <= '0;
        end else begin
            ready <= 1'b0;
            error <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (valid) begin
                        wdata_o <= wdata;
                        wstrb_o <= wstrb;
                        if (|wstrb) begin
                            awaddr    <= addr;
                            awvalid   <= 1'b1;
                            wvalid    <= 1'b1;
                            state_reg <= WR;
                        end else begin
                            araddr    <= addr;
                            arvalid   <= 1'b1;
                            state_reg <= RD;
                        end
                    end
                end
                WR: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wready) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_ok && w_ok) begin
                        bready    <= 1'b1;
                        state_reg <= WRESP;
                    end
                end
                WRESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        error     <= bresp[1];
                        ready     <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                RD: begin
                    if (arready) begin
                        arvalid   <= 1'b0;
                        rready    <= 1'b1;
                        state_reg <= RDATA;
                    end
                end
                RDATA: begin
                    if (rvalid) begin
                        rdata     <= rdata_i;
                        error     <= rresp[1];
                        rready    <= 1'b0;
                        ready     <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // The requester still holds valid this cycle; it must not start a second transfer.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // AXI handshake rules and completion invariants.
    a_aw_hold: assert property (@(posedge clk) disable iff (!rst)
        awvalid && !awready |=> awvalid);
    a_w_hold: assert property (@(posedge clk) disable iff (!rst)
        wvalid && !wready |=> wvalid);
    a_ar_hold: assert property (@(posedge clk) disable iff (!rst)
        arvalid && !arready |=> arvalid);
    a_error_with_ready: assert property (@(posedge clk) disable iff (!rst)
        error |-> ready);
    a_ready_pulse: assert property (@(posedge clk) disable iff (!rst)
        ready |=> !ready);
    a_one_direction: assert property (@(posedge clk) disable iff (!rst)
        !((awvalid || wvalid || bready) && (arvalid || rready)));

endmodule
